axi_gpio: RTL and testbench
===========================

// Module: axi_gpio
// PURPOSE
//  AXI4-Lite slave providing one 32-bit output-only GPIO channel; memory-mapped peripheral on the SoC bus.
//  Bus writes to GPIO_DATA drive gpio_io_o directly; registers read back over the same interface.
//  Single clock domain. No interrupts. No input or tristate pins.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  AXI data width; only 32 is supported.
//  C_S_AXI_ADDR_WIDTH  9   AXI address width; 512-byte register window.
//  C_GPIO_WIDTH        32  GPIO output width, 1..32; unused upper data bits read 0.
//  C_DOUT_DEFAULT      32'h0  GPIO_DATA reset value.
// PORTS
//  s_axi_aclk     in   1   Clock; all logic on its rising edge.
//  s_axi_aresetn  in   1   Reset: asynchronous, active-low.
//  s_axi_awaddr   in   9   Write address.
//  s_axi_awvalid  in   1   Write address valid.
//  s_axi_awready  out  1   Write address ready.
//  s_axi_wdata    in   32  Write data.
//  s_axi_wstrb    in   4   Write byte strobes.
//  s_axi_wvalid   in   1   Write data valid.
//  s_axi_wready   out  1   Write data ready.
//  s_axi_bresp    out  2   Write response; always 2'b00 OKAY.
//  s_axi_bvalid   out  1   Write response valid.
//  s_axi_bready   in   1   Write response ready.
//  s_axi_araddr   in   9   Read address.
//  s_axi_arvalid  in   1   Read address valid.
//  s_axi_arready  out  1   Read address ready.
//  s_axi_rdata    out  32  Read data.
//  s_axi_rresp    out  2   Read response; always 2'b00 OKAY.
//  s_axi_rvalid   out  1   Read data valid.
//  s_axi_rready   in   1   Read data ready.
//  gpio_io_o      out  C_GPIO_WIDTH  GPIO outputs; equal to GPIO_DATA register.
// BEHAVIOUR
//  Register map (decode awaddr/araddr[8:2]; [1:0] ignored):
//   0x000 GPIO_DATA  RW  reset C_DOUT_DEFAULT.
//   0x004 GPIO_TRI   RO  reads 32'h0 (all pins outputs); writes ignored.
//   Other offsets: read 0; writes ignored; response OKAY.
//  Reset (async assert, sync release):
//   - all ready/valid outputs 0; rdata 0; resp 0.
//   - GPIO_DATA = C_DOUT_DEFAULT.
//  Write channel:
//   - Condition: awvalid & wvalid & !awready & !bvalid.
//   - On that condition, awready and wready assert together for exactly one cycle.
//   - Handshake edge (awready & awvalid & wready & wvalid): bytes with wstrb[i]=1 update GPIO_DATA[8i+7:8i].
//   - Same edge sets bvalid.
//   - gpio_io_o changes on the cycle after the handshake edge.
//   - bvalid holds until the bready handshake.
//   - No new write is accepted while bvalid=1 or in the cycle it clears.
//   - A master holding AW/W valid one cycle past the response causes no second write and no second response.
//   - AW alone or W alone is never accepted; the slave waits for both.
//  Read channel:
//   - Condition: arvalid & !arready & !rvalid; arready pulses one cycle.
//   - Handshake edge: rdata is registered from the addressed register and rvalid is set.
//   - rdata/rvalid hold until rready; rdata remains stable while rvalid=1.
//   - No new read is accepted while rvalid=1.
//  Read and write channels are independent and may complete in the same cycle.
//   - A read of GPIO_DATA returns the value before a write completing on the same edge.
//  Reset mid-transaction: the transaction is aborted, all valid/ready flags clear, and GPIO_DATA returns to its default.
// STRUCTURE
//  Package axi_gpio_pkg: register offsets (GPIO_DATA_OFF=9'h000, GPIO_TRI_OFF=9'h004) and AXI_RESP_OKAY=2'b00.
//  Single module. The write and read handshakes are two small always_ff blocks, plus one register-file block. No sub-module.
// TESTING
//  1. Release reset at 100 ns -> gpio_io_o=0, all valid/ready outputs 0, bresp/rresp=0.
//  2. AW=0x000 and W=0xA5A5A5A5 (wstrb=4'hF) together, bready=1
//     -> one awready/wready pulse, then one bvalid, bresp=OKAY; gpio_io_o=0xA5A5A5A5.
//     Holding valids one extra cycle after bvalid -> exactly one bvalid pulse.
//  3. Read 0x004, rready=1 -> rvalid with rdata=0x00000000, rresp=OKAY. Read 0x000 -> rdata=0xA5A5A5A5.
//  4. Write 0x12345678 to 0x000 with wstrb=4'b0101 -> gpio_io_o=0xA534A578.
//  5. Write to 0x100 -> OKAY, gpio_io_o unchanged; read 0x100 -> 0.
//  6. bready held low 5 cycles -> bvalid stays high and no further awready.
//     Assert aresetn=0 mid-read -> rvalid drops immediately and gpio_io_o=0.

Source files
------------

// File: rtl/axi_gpio_pkg.sv
// Shared constants for the AXI4-Lite output-only GPIO peripheral.
package axi_gpio_pkg;

  localparam int unsigned AXI_ADDR_W    = 9;
  localparam int unsigned AXI_DATA_W    = 32;
  localparam int unsigned AXI_STRB_W    = AXI_DATA_W / 8;

  localparam logic [AXI_ADDR_W-1:0] GPIO_DATA_OFF = 9'h000;
  localparam logic [AXI_ADDR_W-1:0] GPIO_TRI_OFF  = 9'h004;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_gpio_if.sv
// AXI4-Lite slave bus bundle for the GPIO peripheral.
interface axi_gpio_if
  import axi_gpio_pkg::*;
#(
  parameter int unsigned ADDR_W = AXI_ADDR_W,
  parameter int unsigned DATA_W = AXI_DATA_W
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_gpio.sv
// AXI4-Lite slave exposing one output-only GPIO channel (GPIO_DATA RW, GPIO_TRI reads 0).
module axi_gpio
  import axi_gpio_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 9,
  parameter int unsigned C_GPIO_WIDTH       = 32,
  parameter logic [31:0] C_DOUT_DEFAULT     = 32'h0
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  axi_gpio_if.slave               s_axi,
  output logic [C_GPIO_WIDTH-1:0] gpio_io_o
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned NB = DW / 8;
  localparam logic [DW-1:0] GPIO_MASK =
    (C_GPIO_WIDTH >= DW) ? {DW{1'b1}} : DW'((64'h1 << C_GPIO_WIDTH) - 64'h1);

  // Word-aligned decode: the two byte-lane address bits are ignored.
  function automatic logic reg_hit(input logic [AW-1:0] addr, input logic [AW-1:0] off);
    return (addr & ~AW'(3)) == off;
  endfunction

  logic          r_aw_wready;
  logic          r_bvalid;
  logic          r_b_clr;
  logic          r_arready;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_gpio_data;

  logic          w_wr_start;
  logic          w_wr_hs;
  logic          w_rd_start;
  logic          w_rd_hs;
  logic [DW-1:0] w_gpio_next;
  logic [DW-1:0] w_rd_mux;

  // A new write waits for both channels, and for the response (plus one cycle) to retire.
  assign w_wr_start = s_axi.awvalid & s_axi.wvalid & ~r_aw_wready & ~r_bvalid & ~r_b_clr;
  assign w_wr_hs    = r_aw_wready & s_axi.awvalid & s_axi.wvalid;
  assign w_rd_start = s_axi.arvalid & ~r_arready & ~r_rvalid;
  assign w_rd_hs    = r_arready & s_axi.arvalid;

  always_comb begin
    w_gpio_next = r_gpio_data;
    for (int i = 0; i < NB; i++) begin
      if (s_axi.wstrb[i]) w_gpio_next[8*i +: 8] = s_axi.wdata[8*i +: 8];
    end
  end

  always_comb begin
    w_rd_mux = '0;
    if (reg_hit(s_axi.araddr, AW'(GPIO_DATA_OFF))) w_rd_mux = r_gpio_data;
    else if (reg_hit(s_axi.araddr, AW'(GPIO_TRI_OFF))) w_rd_mux = '0;
  end

  // Write handshake: one-cycle AW/W ready pulse, then a held response.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_aw_wready <= 1'b0;
      r_bvalid    <= 1'b0;
      r_b_clr     <= 1'b0;
    end else begin
      r_aw_wready <= w_wr_start;
      r_b_clr     <= r_bvalid & s_axi.bready;
      if (w_wr_hs)           r_bvalid <= 1'b1;
      else if (s_axi.bready) r_bvalid <= 1'b0;
    end
  end

  // Read handshake: rdata captured at the address handshake and held until rready.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= w_rd_start;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_mux;
      end else if (s_axi.rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_gpio_data <= DW'(C_DOUT_DEFAULT) & GPIO_MASK;
    end else if (w_wr_hs && reg_hit(s_axi.awaddr, AW'(GPIO_DATA_OFF))) begin
      r_gpio_data <= w_gpio_next & GPIO_MASK;
    end
  end

  assign s_axi.awready = r_aw_wready;
  assign s_axi.wready  = r_aw_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = AXI_RESP_OKAY;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = AXI_RESP_OKAY;
  assign gpio_io_o     = r_gpio_data[C_GPIO_WIDTH-1:0];

endmodule

// File: tb/tb_axi_gpio.sv
// Directed bench for axi_gpio: register writes/reads, strobes, hold-off and reset abort.
module tb_axi_gpio;

  logic        clk;
  logic        rst_n;
  logic [31:0] gpio;

  int n_vec  = 0;
  int n_miss = 0;
  int n_wr_hs = 0;
  int n_b_hs  = 0;

  axi_gpio_if bus ();

  axi_gpio #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (9),
    .C_GPIO_WIDTH       (32),
    .C_DOUT_DEFAULT     (32'h0)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi         (bus),
    .gpio_io_o     (gpio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.awready && bus.awvalid && bus.wready && bus.wvalid) n_wr_hs++;
    if (bus.bvalid && bus.bready) n_b_hs++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_awready();
    int t = 0;
    do begin @(negedge clk); t++; end while (!bus.awready && t < 20);
    check("aw_ready_seen", 32'(bus.awready), 32'd1);
  endtask

  task automatic wait_arready();
    int t = 0;
    do begin @(negedge clk); t++; end while (!bus.arready && t < 20);
    check("ar_ready_seen", 32'(bus.arready), 32'd1);
  endtask

  task automatic axi_wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                        input bit hold);
    int hs0, b0;
    hs0 = n_wr_hs;
    b0  = n_b_hs;
    @(negedge clk);
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata  = d; bus.wstrb   = s; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    wait_awready();
    check("wr_wready", 32'(bus.wready), 32'd1);
    @(negedge clk);
    check("wr_bvalid", 32'(bus.bvalid), 32'd1);
    check("wr_bresp", 32'(bus.bresp), 32'd0);
    if (hold) begin
      @(negedge clk);
      check("hold_bvalid_clr", 32'(bus.bvalid), 32'd0);
      @(negedge clk);
      check("hold_awready", 32'(bus.awready), 32'd0);
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("wr_hs_count", 32'(n_wr_hs - hs0), 32'd1);
    check("wr_b_count", 32'(n_b_hs - b0), 32'd1);
  endtask

  task automatic axi_rd(input logic [8:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    wait_arready();
    @(negedge clk);
    check("rd_rvalid", 32'(bus.rvalid), 32'd1);
    check("rd_rdata", bus.rdata, exp);
    check("rd_rresp", 32'(bus.rresp), 32'd0);
    bus.arvalid = 1'b0;
    @(negedge clk);
    check("rd_rvalid_clr", 32'(bus.rvalid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    #100 rst_n = 1'b1;
    #1;
    check("rst_gpio", gpio, 32'h0);
    check("rst_ready", {28'h0, bus.awready, bus.wready, bus.arready, 1'b0}, 32'h0);
    check("rst_valid", {30'h0, bus.bvalid, bus.rvalid}, 32'h0);
    check("rst_resp", {28'h0, bus.bresp, bus.rresp}, 32'h0);

    // Full write with valids held one cycle past the response
    axi_wr(9'h000, 32'hA5A5_A5A5, 4'hF, 1'b1);
    check("gpio_a5", gpio, 32'hA5A5_A5A5);

    axi_rd(9'h004, 32'h0);
    axi_rd(9'h000, 32'hA5A5_A5A5);

    // Byte lanes 0 and 2 only
    axi_wr(9'h000, 32'h1234_5678, 4'b0101, 1'b0);
    check("gpio_strb", gpio, 32'hA534_A578);
    axi_rd(9'h002, 32'hA534_A578);

    axi_wr(9'h100, 32'hFFFF_FFFF, 4'hF, 1'b0);
    check("gpio_unmapped", gpio, 32'hA534_A578);
    axi_rd(9'h100, 32'h0);
    axi_wr(9'h004, 32'hFFFF_FFFF, 4'hF, 1'b0);
    check("gpio_tri_wr", gpio, 32'hA534_A578);
    axi_rd(9'h004, 32'h0);

    // Read and write of GPIO_DATA completing on the same edge
    @(negedge clk);
    bus.awaddr = 9'h000; bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    bus.araddr = 9'h000; bus.arvalid = 1'b1; bus.rready = 1'b1;
    @(negedge clk);
    check("same_awready", 32'(bus.awready), 32'd1);
    check("same_arready", 32'(bus.arready), 32'd1);
    @(negedge clk);
    check("same_bvalid", 32'(bus.bvalid), 32'd1);
    check("same_rvalid", 32'(bus.rvalid), 32'd1);
    check("same_rdata_old", bus.rdata, 32'hA534_A578);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    @(negedge clk);
    check("same_gpio_new", gpio, 32'hDEAD_BEEF);

    // Response back-pressure: bvalid holds, a pending second write is not accepted
    @(negedge clk);
    bus.awaddr = 9'h000; bus.wdata = 32'h00FF_00FF; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    wait_awready();
    @(negedge clk);
    check("bp_bvalid", 32'(bus.bvalid), 32'd1);
    bus.wdata = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_bvalid_hold", 32'(bus.bvalid), 32'd1);
      check("bp_no_awready", 32'(bus.awready), 32'd0);
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    @(negedge clk);
    check("bp_bvalid_clr", 32'(bus.bvalid), 32'd0);
    check("bp_gpio", gpio, 32'h00FF_00FF);

    // Reset while a read response is pending
    @(negedge clk);
    bus.araddr = 9'h000; bus.arvalid = 1'b1; bus.rready = 1'b0;
    wait_arready();
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("mid_rvalid", 32'(bus.rvalid), 32'd1);
    check("mid_rdata", bus.rdata, 32'h00FF_00FF);
    @(negedge clk);
    check("mid_rvalid_hold", 32'(bus.rvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_rvalid", 32'(bus.rvalid), 32'd0);
    check("abort_gpio", gpio, 32'h0);
    check("abort_flags", {28'h0, bus.awready, bus.bvalid, bus.arready, 1'b0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rready = 1'b1;
    axi_rd(9'h000, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
